// File: rtl/ct_f_spsram_param.sv
// Parametrised single-port synchronous SRAM with segmented writes,
// optional output register, read-valid strobe and init sweep.
//
// Ports:
//   CLK       clock, all state on rising edge
//   RST       asynchronous active-high reset
//   A         address
//   CEN       chip enable, active-low
//   GWEN      global write enable, active-low (1 = read)
//   WEN       per-bit write enable, active-low; only the top bit of
//             each segment is looked at
//   D         write data
//   INIT_REQ  single-cycle request to re-run the init sweep
//   Q         read data
//   Q_VLD     one-cycle strobe marking fresh read data on Q
//   INIT_BUSY init sweep running, accesses ignored
module ct_f_spsram_param #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 54,
  parameter int SEG_WIDTH  = 27,
  parameter int OUT_REG    = 0,
  parameter int INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  INIT_REQ,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VLD,
  output logic                  INIT_BUSY
);

  localparam int NSEG  = DATA_WIDTH / SEG_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  state_e                  state_q;
  state_e                  state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]   cnt_d;
  logic [ADDR_WIDTH-1:0]   hold_q;
  logic [ADDR_WIDTH-1:0]   hold_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_mask;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [DATA_WIDTH-1:0]   seg_mask;

  logic [DATA_WIDTH-1:0]   q_q;
  logic                    vld_q;

  // Only the top bit of each segment's WEN slice matters; the rest
  // is folded here so it is visibly consumed.
  logic                    unused_wen;
  assign unused_wen = ^WEN;

  // Expand the per-segment enable bit into a full-width bit mask.
  always_comb begin
    seg_mask = '0;
    for (int k = 0; k < NSEG; k++) begin
      seg_mask[k*SEG_WIDTH +: SEG_WIDTH] =
        {SEG_WIDTH{~WEN[(k+1)*SEG_WIDTH-1]}};
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= (INIT_EN != 0) ? S_INIT : S_READY;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Next state and array port control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    wr_en   = 1'b0;
    wr_addr = A;
    wr_mask = '0;
    wr_data = D;
    rd_en   = 1'b0;
    unique case (state_q)
      S_INIT: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_mask = '1;
        wr_data = INIT_VAL;
        // Wraps to 0 only after the terminal address.
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (INIT_REQ) begin
          cnt_d   = '0;
          state_d = S_INIT;
        end else if (!CEN) begin
          hold_d = A;
          if (!GWEN) begin
            wr_en   = 1'b1;
            wr_mask = seg_mask;
          end else begin
            rd_en = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_READY;
      end
    endcase
  end

  // A deselected port keeps pointing at the last accepted address.
  assign rd_addr = CEN ? hold_q : A;
  assign rd_data = mem_q[rd_addr];

  // Array: not reset, only the sweep defines its contents.
  always_ff @(posedge CLK) begin
    if (wr_en && !RST) begin
      mem_q[wr_addr] <= (mem_q[wr_addr] & ~wr_mask) |
                        (wr_data & wr_mask);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] pipe_q;
      logic                  pipe_vld_q;

      // The second stage advances regardless of FSM state so a read
      // already in flight when a sweep starts still delivers.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          pipe_q     <= '0;
          pipe_vld_q <= 1'b0;
          q_q        <= '0;
          vld_q      <= 1'b0;
        end else begin
          pipe_vld_q <= rd_en;
          if (rd_en) begin
            pipe_q <= rd_data;
          end
          vld_q <= pipe_vld_q;
          if (pipe_vld_q) begin
            q_q <= pipe_q;
          end
        end
      end
    end else begin : g_noreg
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          q_q   <= '0;
          vld_q <= 1'b0;
        end else begin
          vld_q <= rd_en;
          if (rd_en) begin
            q_q <= rd_data;
          end
        end
      end
    end
  endgenerate

  assign Q         = q_q;
  assign Q_VLD     = vld_q;
  assign INIT_BUSY = (state_q == S_INIT);

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Bench for ct_f_spsram_param: one instance without and one with the
// output register, driven in lockstep and checked against a model.
module tb_ct_f_spsram_param;

  localparam int AW = 8;
  localparam int DW = 54;
  localparam logic [DW-1:0] IV = 54'h3F_FFFF_0000_1234;
  localparam logic [DW-1:0] WALL = {DW{1'b1}};
  localparam logic [DW-1:0] WLO = ~(54'd1 << 26);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] A = '0;
  logic          CEN = 1'b1;
  logic          GWEN = 1'b1;
  logic [DW-1:0] WEN = '1;
  logic [DW-1:0] D = '0;
  logic          IREQ = 1'b0;
  logic [DW-1:0] Q0, Q1;
  logic          V0, V1, B0, B1;

  always #5 CLK = ~CLK;

  ct_f_spsram_param #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEG_WIDTH(27),
    .OUT_REG(0), .INIT_EN(1), .INIT_VAL(IV)
  ) u0 (
    .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN),
    .WEN(WEN), .D(D), .INIT_REQ(IREQ),
    .Q(Q0), .Q_VLD(V0), .INIT_BUSY(B0)
  );

  ct_f_spsram_param #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEG_WIDTH(27),
    .OUT_REG(1), .INIT_EN(1), .INIT_VAL(IV)
  ) u1 (
    .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN),
    .WEN(WEN), .D(D), .INIT_REQ(IREQ),
    .Q(Q1), .Q_VLD(V1), .INIT_BUSY(B1)
  );

  // Reference model: word array, remaining sweep cycles, and the read
  // events of the last two edges (latency 1 and latency 2 outputs).
  logic [DW-1:0] mm [256];
  int            busy_left;
  bit            hv [2];
  logic [DW-1:0] hd [2];
  logic [DW-1:0] q0e, q1e;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic          cen;
    logic          gwen;
    logic [DW-1:0] wen;
    logic [DW-1:0] d;
    logic          ev;
    logic [DW-1:0] eq;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic check_all();
    chk("busy0", 64'(B0), 64'(busy_left > 0));
    chk("busy1", 64'(B1), 64'(busy_left > 0));
    chk("vld0", 64'(V0), 64'(hv[0]));
    chk("q0", 64'(Q0), 64'(q0e));
    chk("vld1", 64'(V1), 64'(hv[1]));
    chk("q1", 64'(Q1), 64'(q1e));
  endtask

  task automatic step(input logic [AW-1:0] a, input logic cen,
                      input logic gwen, input logic [DW-1:0] wen,
                      input logic [DW-1:0] d, input logic ir);
    bit            rd;
    logic [DW-1:0] rdat;
    A = a; CEN = cen; GWEN = gwen; WEN = wen; D = d; IREQ = ir;
    rd = 1'b0;
    rdat = '0;
    if (busy_left > 0) begin
      mm[8'(256 - busy_left)] = IV;
      busy_left--;
    end else if (ir) begin
      busy_left = 256;
    end else if (!cen) begin
      if (!gwen) begin
        if (!wen[26]) mm[a][26:0] = d[26:0];
        if (!wen[53]) mm[a][53:27] = d[53:27];
      end else begin
        rd = 1'b1;
        rdat = mm[a];
      end
    end
    hv[1] = hv[0]; hd[1] = hd[0];
    hv[0] = rd;    hd[0] = rdat;
    if (hv[0]) q0e = hd[0];
    if (hv[1]) q1e = hd[1];
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(8'h00, 1'b1, 1'b1, WALL, '0, 1'b0);
  endtask

  task automatic rnd_step(input int ir_pct);
    logic [AW-1:0] a;
    logic [DW-1:0] w, d;
    a = AW'($urandom_range(0, 15));
    w = DW'({$urandom(), $urandom()});
    d = DW'({$urandom(), $urandom()});
    step(a, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
         w, d, 1'($urandom_range(0, 999) < ir_pct));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    busy_left = 256;
    hv[0] = 0; hv[1] = 0;
    hd[0] = '0; hd[1] = '0;
    q0e = '0; q1e = '0;
    #1;
    chk("rst_busy", 64'(B0), 64'd1);
    chk("rst_q0", 64'(Q0), 64'd0);
    chk("rst_vld0", 64'(V0), 64'd0);
    chk("rst_q1", 64'(Q1), 64'd0);
    chk("rst_vld1", 64'(V1), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (B0 && n < 1000) begin
      n++;
      rnd_step(500);
    end
  endtask

  initial begin
    int n;
    tbl[0]  = '{8'h00, 1'b0, 1'b1, WALL, '0, 1'b1, IV};
    tbl[1]  = '{8'hFF, 1'b0, 1'b1, WALL, '0, 1'b1, IV};
    tbl[2]  = '{8'h10, 1'b0, 1'b0, '0, '0, 1'b0, IV};
    tbl[3]  = '{8'h10, 1'b0, 1'b0, WLO,
                {27'h2AAAAAA, 27'h5555555}, 1'b0, IV};
    tbl[4]  = '{8'h10, 1'b0, 1'b1, WALL, '0, 1'b1, 54'h5555555};
    tbl[5]  = '{8'h33, 1'b1, 1'b1, WALL, '0, 1'b0, 54'h5555555};
    tbl[6]  = '{8'h40, 1'b0, 1'b0, '0, 54'h123, 1'b0, 54'h5555555};
    tbl[7]  = '{8'h40, 1'b0, 1'b1, WALL, '0, 1'b1, 54'h123};
    tbl[8]  = '{8'h40, 1'b1, 1'b0, '0, 54'hFFF, 1'b0, 54'h123};
    tbl[9]  = '{8'h40, 1'b0, 1'b1, WALL, '0, 1'b1, 54'h123};
    tbl[10] = '{8'h41, 1'b0, 1'b0, WALL, 54'h777, 1'b0, 54'h123};
    tbl[11] = '{8'h41, 1'b0, 1'b1, WALL, '0, 1'b1, IV};

    // Power-up sweep
    do_reset();
    wait_busy(n);
    chk("init_len", 64'(n), 64'd256);

    // Directed vectors on the unregistered instance
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].a, tbl[i].cen, tbl[i].gwen, tbl[i].wen, tbl[i].d,
           1'b0);
      chk($sformatf("tbl%0d_vld", i), 64'(V0), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_q", i), 64'(Q0), 64'(tbl[i].eq));
    end

    // Back-to-back reads through the output register
    step(8'h01, 1'b0, 1'b0, '0, 54'hA1, 1'b0);
    step(8'h02, 1'b0, 1'b0, '0, 54'hA2, 1'b0);
    step(8'h03, 1'b0, 1'b0, '0, 54'hA3, 1'b0);
    idle();
    step(8'h01, 1'b0, 1'b1, WALL, '0, 1'b0);
    chk("pipe_r1_vld", 64'(V1), 64'd0);
    step(8'h02, 1'b0, 1'b1, WALL, '0, 1'b0);
    chk("pipe_r2_vld", 64'(V1), 64'd1);
    chk("pipe_r2_q", 64'(Q1), 64'hA1);
    step(8'h03, 1'b0, 1'b1, WALL, '0, 1'b0);
    chk("pipe_r3_q", 64'(Q1), 64'hA2);
    step(8'h7E, 1'b1, 1'b1, WALL, '0, 1'b0);
    chk("pipe_r4_vld", 64'(V1), 64'd1);
    chk("pipe_r4_q", 64'(Q1), 64'hA3);
    step(8'h7E, 1'b1, 1'b1, WALL, '0, 1'b0);
    chk("pipe_hold_vld", 64'(V1), 64'd0);
    chk("pipe_hold_q", 64'(Q1), 64'hA3);

    // INIT_REQ drops a coincident write; in-flight read completes
    step(8'h05, 1'b0, 1'b0, '0, 54'hBEEF, 1'b0);
    step(8'h07, 1'b0, 1'b1, WALL, '0, 1'b0);
    step(8'h05, 1'b0, 1'b0, '0, 54'h5A5, 1'b1);
    chk("ireq_busy", 64'(B0), 64'd1);
    chk("ireq_vld0", 64'(V0), 64'd0);
    chk("ireq_inflight", 64'(V1), 64'd1);
    chk("ireq_inflight_q", 64'(Q1), 64'(IV));
    wait_busy(n);
    chk("ireq_len", 64'(n), 64'd256);
    step(8'h05, 1'b0, 1'b1, WALL, '0, 1'b0);
    chk("ireq_dropped", 64'(Q0), 64'(IV));

    // Reset during a pending read, then mid-sweep
    step(8'h05, 1'b0, 1'b1, WALL, '0, 1'b0);
    do_reset();
    for (int i = 0; i < 100; i++) rnd_step(500);
    do_reset();
    wait_busy(n);
    chk("rst_mid_len", 64'(n), 64'd256);

    // Random traffic with occasional re-init
    for (int i = 0; i < 3000; i++) rnd_step(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
